serial_addsub_ctrl: RTL and testbench

//  Bit-serial add/subtract controller: time-multiplexes one 1-bit FullAdder cell over WIDTH cycles.

---
 rtl/serial_addsub_pkg.sv | 21 ++
 rtl/serial_addsub_ctrl_full_adder.sv | 28 ++
 rtl/serial_addsub_ctrl.sv | 115 +++++++++++
 tb/tb_serial_addsub_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding and the counter-width helper.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Bits needed to count 0..value-1; never less than one bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/serial_addsub_ctrl_full_adder.sv
// One-bit full adder cell built from two half adders; the serial
// controller time-multiplexes a single instance of it.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b;
   assign carry = a & b;
endmodule

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic s1;
   logic c1;
   logic c2;

   half_adder u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
   half_adder u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));

   assign cout = c1 | c2;
endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract: one full adder cell walks the operands LSB-first
// over WIDTH cycles, building the result in a shift register.
module serial_addsub_ctrl
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_sub,
   input  logic [WIDTH-1:0] i_A,
   input  logic [WIDTH-1:0] i_B,
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_overflow,
   output logic [1:0]       o_state
);

   localparam int CW = clog2(WIDTH);

   // Handshake: an op is accepted on any rising edge where i_start=1 and
   // o_ready=1; operands and i_sub are sampled only on that edge.
   state_t           state_q;
   state_t           state_d;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_out_q;
   logic             overflow_q;
   logic             accept;
   logic             last_bit;
   logic             fa_sum;
   logic             fa_cout;

   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign last_bit = (count_q == CW'(WIDTH - 1));

   always_comb begin
      state_d = ST_IDLE;
      o_ready = 1'b1;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      case (state_q)
         ST_SHIFT: begin
            o_ready = 1'b0;
            o_busy  = 1'b1;
            state_d = last_bit ? ST_DONE : ST_SHIFT;
         end
         ST_DONE: begin
            o_done  = 1'b1;
            state_d = i_start ? ST_SHIFT : ST_IDLE;
         end
         // ST_IDLE and the unused encoding 2'd3 both behave as idle.
         default: begin
            state_d = i_start ? ST_SHIFT : ST_IDLE;
         end
      endcase
      accept = i_start & o_ready;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         a_sh        <= '0;
         b_sh        <= '0;
         carry_q     <= 1'b0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry.
            a_sh        <= i_A;
            b_sh        <= i_sub ? ~i_B : i_B;
            carry_q     <= i_sub;
            count_q     <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
         end else if (state_q == ST_SHIFT) begin
            result_q <= {fa_sum, result_q[WIDTH-1:1]};
            a_sh     <= a_sh >> 1;
            b_sh     <= b_sh >> 1;
            carry_q  <= fa_cout;
            count_q  <= count_q + 1'b1;
            if (last_bit) begin
               carry_out_q <= fa_cout;
               overflow_q  <= carry_q ^ fa_cout;
            end
         end
      end
   end

   // Partial sums are hidden while the op is in flight.
   assign o_result   = o_busy ? '0 : result_q;
   assign o_carry    = carry_out_q;
   assign o_overflow = overflow_q;
   assign o_state    = state_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl (WIDTH=4): driver tasks push expected results
// from an arithmetic model; a negedge monitor pops and compares on o_done.
module tb_serial_addsub_ctrl;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry;
   logic         overflow;
   logic [1:0]   state;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [W+1:0] exp_q[$];
   int           exp_cyc_q[$];

   serial_addsub_ctrl #(.WIDTH(W)) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_start    (start),
      .i_sub      (sub),
      .i_A        (a),
      .i_B        (b),
      .o_ready    (ready),
      .o_busy     (busy),
      .o_done     (done),
      .o_result   (result),
      .o_carry    (carry),
      .o_overflow (overflow),
      .o_state    (state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W+1:0] model(input int ua, input int ub, input bit s);
      int sa;
      int sb;
      int sr;
      int ur;
      bit c;
      bit v;
      sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
      sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
      if (s) begin
         ur = ua - ub;
         sr = sa - sb;
         c  = (ua >= ub);
      end else begin
         ur = ua + ub;
         sr = sa + sb;
         c  = (ur >= (1 << W));
      end
      v = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
      return {W'(ur), c, v};
   endfunction

   // ---------------- driver ----------------
   task automatic issue_op(input int ua, input int ub, input bit s);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout: ready stayed low for 100 cycles");
      end
      start = 1'b1;
      a     = W'(ua);
      b     = W'(ub);
      sub   = s;
      @(posedge clk);
      #1;
      exp_q.push_back(model(ua, ub, s));
      exp_cyc_q.push_back(cyc + W);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (busy) begin
            check("busy_outputs_zero", {result, carry, overflow}, '0);
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: done with empty queue at cycle %0d", cyc);
            end else begin
               check("result_carry_ovf", {result, carry, overflow}, exp_q.pop_front());
               check("done_latency", cyc, exp_cyc_q.pop_front());
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", ready, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_outputs", {result, carry, overflow}, '0);
      check("reset_state", state, 2'd0);
      rst = 1'b0;

      // Directed cases
      issue_op(3, 5, 0);
      drain();
      check("add_3_5_result_held", {result, carry, overflow}, {4'b1000, 1'b0, 1'b1});
      issue_op(7, 2, 1);
      issue_op(2, 7, 1);
      issue_op(15, 1, 0);
      issue_op(4, 4, 0);
      drain();

      // Start during SHIFT is ignored
      issue_op(3, 5, 0);
      @(negedge clk);
      start = 1'b1;
      a     = 4'd9;
      b     = 4'd1;
      sub   = 1'b0;
      @(negedge clk);
      start = 1'b0;
      drain();
      check("ignored_start_result", result, 4'b1000);

      // Back-to-back: the second op is accepted in the DONE cycle
      issue_op(3, 5, 0);
      issue_op(6, 1, 1);
      drain();
      check("b2b_result", result, 4'b0101);

      // Reset mid-SHIFT aborts the op
      issue_op(9, 3, 0);
      void'(exp_q.pop_back());
      void'(exp_cyc_q.pop_back());
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_ready", ready, 1'b1);
      check("abort_result", result, 4'd0);
      check("abort_done", done, 1'b0);
      repeat (W + 2) @(negedge clk);
      check("abort_no_done_queue", 32'(exp_q.size()), 32'd0);
      issue_op(1, 1, 0);
      drain();
      check("post_abort_result", result, 4'b0010);

      // Randomized ops, with occasional idle gaps
      for (int i = 0; i < 40; i++) begin
         issue_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
      end
      drain();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
